// File: rtl/wb_multistrand_stage.sv
// Writeback stage: per-strand fill-wait FSM, scalar/vector load formatting and rollback generation.
// Memory ops decode as instr[31:30]=2'b10, instr[29]=load, instr[28:25]=MEM_* type.
// Optional WB_PERF_COUNTERS_EN adds per-strand 64-bit retire counters.
module wb_multistrand_stage #(
    parameter int unsigned NUM_STRANDS = 4,
    parameter int unsigned NUM_LANES   = 16,
    parameter int unsigned LANE_WIDTH  = 32,
    localparam int unsigned SW = (NUM_STRANDS > 1) ? $clog2(NUM_STRANDS) : 1,
    localparam int unsigned LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
    localparam int unsigned VW = NUM_LANES * LANE_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [31:0]            ma_instruction,
    input  logic [31:0]            ma_pc,
    input  logic [SW-1:0]          ma_strand,
    input  logic                   ma_has_writeback,
    input  logic [6:0]             ma_writeback_reg,
    input  logic                   ma_writeback_is_vector,
    input  logic [NUM_LANES-1:0]   ma_mask,
    input  logic [VW-1:0]          ma_result,
    input  logic                   ma_was_load,
    input  logic [LW-1:0]          ma_reg_lane_select,
    input  logic [LW-1:0]          ma_cache_lane_select,
    input  logic                   dcache_hit,
    input  logic                   dcache_load_collision,
    input  logic                   stbuf_rollback,
    input  logic [VW-1:0]          data_from_dcache,
    input  logic [NUM_STRANDS-1:0] resume_strand,
    input  logic [SW-1:0]          perf_strand_sel,
    output logic                   wb_has_writeback,
    output logic                   wb_writeback_is_vector,
    output logic [6:0]             wb_writeback_reg,
    output logic [VW-1:0]          wb_writeback_value,
    output logic [NUM_LANES-1:0]   wb_writeback_mask,
    output logic [SW-1:0]          wb_writeback_strand,
    output logic                   wb_rollback_request,
    output logic [31:0]            wb_rollback_pc,
    output logic [SW-1:0]          wb_rollback_strand,
    output logic                   wb_retry,
    output logic [NUM_STRANDS-1:0] strand_waiting,
    output logic [63:0]            perf_retire_count
);
    localparam logic [0:0] ST_ACTIVE    = 1'b0;
    localparam logic [0:0] ST_WAIT_FILL = 1'b1;

    localparam logic [3:0] MEM_B      = 4'd0;
    localparam logic [3:0] MEM_BX     = 4'd1;
    localparam logic [3:0] MEM_S      = 4'd2;
    localparam logic [3:0] MEM_SX     = 4'd3;
    localparam logic [3:0] MEM_SYNC   = 4'd5;
    localparam logic [3:0] MEM_BLOCK  = 4'd7;
    localparam logic [3:0] MEM_STRIDE = 4'd10;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    logic [NUM_STRANDS-1:0] state_q, state_d;
    logic                   has_wb_q, has_wb_d;
    logic                   is_vec_q;
    logic [6:0]             reg_q;
    logic [NUM_LANES-1:0][LANE_WIDTH-1:0] val_q, val_d;
    logic [NUM_LANES-1:0]   mask_q, mask_d;
    logic [SW-1:0]          wbs_q;

    logic [NUM_LANES-1:0][LANE_WIDTH-1:0] dc_lane, res_lane;
    logic [SW-1:0]   strand_idx;
    logic            live, enter_wait, rb_req_c;
    logic [31:0]     rb_pc_c, cache_word, aligned;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [3:0]      op;
    logic            is_mem, is_ld, scalar_ld, block_ld, lane_ld, sync_st;

    assign dc_lane  = data_from_dcache;
    assign res_lane = ma_result;

    // Strand select, instruction decode and scalar load alignment
    always_comb begin
        strand_idx = ma_strand;
        if (32'(ma_strand) >= NUM_STRANDS) strand_idx = '0;
        live = 1'b0;
        for (int i = 0; i < NUM_STRANDS; i++)
            if (SW'(i) == strand_idx) live = (state_q[i] == ST_ACTIVE);

        op        = ma_instruction[28:25];
        is_mem    = (ma_instruction[31:30] == 2'b10);
        is_ld     = is_mem && ma_instruction[29];
        scalar_ld = is_ld && (op <= MEM_SYNC);
        block_ld  = is_ld && (op >= MEM_BLOCK) && (op < MEM_STRIDE);
        lane_ld   = is_ld && (op >= MEM_STRIDE);
        sync_st   = is_mem && !ma_instruction[29] && (op == MEM_SYNC);

        cache_word = 32'(dc_lane[ma_cache_lane_select]);
        case (ma_result[1:0])
            2'd0:    ld_byte = cache_word[31:24];
            2'd1:    ld_byte = cache_word[23:16];
            2'd2:    ld_byte = cache_word[15:8];
            default: ld_byte = cache_word[7:0];
        endcase
        ld_half = ma_result[1] ? cache_word[15:0] : cache_word[31:16];
        case (op)
            MEM_B:   aligned = {24'd0, ld_byte};
            MEM_BX:  aligned = {{24{ld_byte[7]}}, ld_byte};
            MEM_S:   aligned = {16'd0, ld_half};
            MEM_SX:  aligned = {{16{ld_half[15]}}, ld_half};
            default: aligned = bswap32(cache_word);
        endcase
    end

    // Rollback priority and per-strand FSM next state
    always_comb begin
        rb_req_c   = 1'b0;
        rb_pc_c    = 32'd0;
        enter_wait = 1'b0;
        if (live) begin
            if (dcache_load_collision) begin
                rb_req_c = 1'b1;
                rb_pc_c  = ma_pc - 32'd4;
            end else if ((ma_was_load && !dcache_hit) || stbuf_rollback) begin
                rb_req_c   = 1'b1;
                rb_pc_c    = ma_pc - 32'd4;
                enter_wait = 1'b1;
            end else if (scalar_ld && ma_has_writeback && !ma_writeback_is_vector
                         && ma_writeback_reg == 7'd31) begin
                rb_req_c = 1'b1;
                rb_pc_c  = aligned;
            end
        end

        state_d = state_q;
        for (int i = 0; i < NUM_STRANDS; i++) begin
            case (state_q[i])
                ST_ACTIVE:    if (enter_wait && SW'(i) == strand_idx) state_d[i] = ST_WAIT_FILL;
                ST_WAIT_FILL: if (resume_strand[i]) state_d[i] = ST_ACTIVE;
                default:      state_d[i] = ST_ACTIVE;
            endcase
        end
    end

    // Writeback data and mask formatting
    always_comb begin
        has_wb_d = ma_has_writeback && live && !rb_req_c;
        val_d    = res_lane;
        mask_d   = ma_mask;
        if (scalar_ld) begin
            for (int l = 0; l < NUM_LANES; l++) val_d[l] = LANE_WIDTH'(aligned);
            mask_d = '1;
        end else if (block_ld) begin
            for (int l = 0; l < NUM_LANES; l++) val_d[l] = LANE_WIDTH'(bswap32(32'(dc_lane[l])));
        end else if (lane_ld) begin
            for (int l = 0; l < NUM_LANES; l++) val_d[l] = LANE_WIDTH'(bswap32(cache_word));
            mask_d = (NUM_LANES'(1) << ma_reg_lane_select) & ma_mask;
        end else if (sync_st) begin
            val_d  = dc_lane;
            mask_d = '1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= '0;
            has_wb_q <= 1'b0;
            is_vec_q <= 1'b0;
            reg_q    <= '0;
            val_q    <= '0;
            mask_q   <= '0;
            wbs_q    <= '0;
        end else begin
            state_q  <= state_d;
            has_wb_q <= has_wb_d;
            is_vec_q <= ma_writeback_is_vector;
            reg_q    <= ma_writeback_reg;
            val_q    <= val_d;
            mask_q   <= mask_d;
            wbs_q    <= strand_idx;
        end
    end

    assign wb_has_writeback       = has_wb_q;
    assign wb_writeback_is_vector = is_vec_q;
    assign wb_writeback_reg       = reg_q;
    assign wb_writeback_value     = val_q;
    assign wb_writeback_mask      = mask_q;
    assign wb_writeback_strand    = wbs_q;
    assign wb_rollback_request    = rb_req_c;
    assign wb_rollback_pc         = rb_pc_c;
    assign wb_rollback_strand     = ma_strand;
    assign wb_retry               = dcache_load_collision;
    assign strand_waiting         = state_q;

`ifdef WB_PERF_COUNTERS_EN
    logic [63:0]   cnt_q [NUM_STRANDS];
    logic [63:0]   cnt_d [NUM_STRANDS];
    logic [63:0]   perf_val;
    logic [SW-1:0] perf_idx;
    logic          retire;

    // Retire counting and read-select mux
    always_comb begin
        retire   = live && (ma_instruction != 32'd0) && !rb_req_c;
        perf_idx = (32'(perf_strand_sel) >= NUM_STRANDS) ? '0 : perf_strand_sel;
        perf_val = 64'd0;
        for (int i = 0; i < NUM_STRANDS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (retire && SW'(i) == strand_idx) cnt_d[i] = cnt_q[i] + 64'd1;
            if (SW'(i) == perf_idx) perf_val = cnt_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_STRANDS; i++) cnt_q[i] <= 64'd0;
        end else begin
            for (int i = 0; i < NUM_STRANDS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign perf_retire_count = perf_val;
`else
    logic unused_inputs;
    assign unused_inputs     = ^{ma_instruction[24:0], perf_strand_sel};
    assign perf_retire_count = 64'd0;
`endif
endmodule

// File: tb/tb_wb_multistrand_stage.sv
// Directed self-checking bench for wb_multistrand_stage (default parameters).
module tb_wb_multistrand_stage;
    logic         clk = 1'b0;
    logic         reset_n;
    logic [31:0]  ma_instruction, ma_pc;
    logic [1:0]   ma_strand, perf_strand_sel;
    logic         ma_has_writeback, ma_writeback_is_vector, ma_was_load;
    logic [6:0]   ma_writeback_reg;
    logic [15:0]  ma_mask;
    logic [511:0] ma_result, data_from_dcache;
    logic [3:0]   ma_reg_lane_select, ma_cache_lane_select;
    logic         dcache_hit, dcache_load_collision, stbuf_rollback;
    logic [3:0]   resume_strand;
    logic         wb_has_writeback, wb_writeback_is_vector;
    logic [6:0]   wb_writeback_reg;
    logic [511:0] wb_writeback_value;
    logic [15:0]  wb_writeback_mask;
    logic [1:0]   wb_writeback_strand, wb_rollback_strand;
    logic         wb_rollback_request, wb_retry;
    logic [31:0]  wb_rollback_pc;
    logic [3:0]   strand_waiting;
    logic [63:0]  perf_retire_count;

    int tests_run = 0;
    int tests_failed = 0;

    logic [15:0][31:0] line, expv;

    wb_multistrand_stage dut (
        .clk(clk), .reset_n(reset_n),
        .ma_instruction(ma_instruction), .ma_pc(ma_pc), .ma_strand(ma_strand),
        .ma_has_writeback(ma_has_writeback), .ma_writeback_reg(ma_writeback_reg),
        .ma_writeback_is_vector(ma_writeback_is_vector), .ma_mask(ma_mask),
        .ma_result(ma_result), .ma_was_load(ma_was_load),
        .ma_reg_lane_select(ma_reg_lane_select), .ma_cache_lane_select(ma_cache_lane_select),
        .dcache_hit(dcache_hit), .dcache_load_collision(dcache_load_collision),
        .stbuf_rollback(stbuf_rollback), .data_from_dcache(data_from_dcache),
        .resume_strand(resume_strand), .perf_strand_sel(perf_strand_sel),
        .wb_has_writeback(wb_has_writeback), .wb_writeback_is_vector(wb_writeback_is_vector),
        .wb_writeback_reg(wb_writeback_reg), .wb_writeback_value(wb_writeback_value),
        .wb_writeback_mask(wb_writeback_mask), .wb_writeback_strand(wb_writeback_strand),
        .wb_rollback_request(wb_rollback_request), .wb_rollback_pc(wb_rollback_pc),
        .wb_rollback_strand(wb_rollback_strand), .wb_retry(wb_retry),
        .strand_waiting(strand_waiting), .perf_retire_count(perf_retire_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_instr(input logic ld, input logic [3:0] op);
        return {2'b10, ld, op, 25'd0};
    endfunction

    task automatic clear_inputs();
        ma_instruction = '0; ma_pc = '0; ma_strand = '0; perf_strand_sel = '0;
        ma_has_writeback = 0; ma_writeback_is_vector = 0; ma_was_load = 0;
        ma_writeback_reg = '0; ma_mask = '0; ma_result = '0; data_from_dcache = '0;
        ma_reg_lane_select = '0; ma_cache_lane_select = '0;
        dcache_hit = 0; dcache_load_collision = 0; stbuf_rollback = 0; resume_strand = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 0;
        clear_inputs();
        #12;
        tests_run++; if (wb_has_writeback !== 1'b0) begin tests_failed++; $display("FAIL reset_has_wb got %0b exp 0", wb_has_writeback); end
        tests_run++; if (strand_waiting !== 4'b0000) begin tests_failed++; $display("FAIL reset_waiting got %b exp 0000", strand_waiting); end
        tests_run++; if (wb_writeback_value !== 512'd0) begin tests_failed++; $display("FAIL reset_value got %0h exp 0", wb_writeback_value); end
        tests_run++; if (perf_retire_count !== 64'd0) begin tests_failed++; $display("FAIL reset_perf got %0d exp 0", perf_retire_count); end
        @(negedge clk);
        reset_n = 1;
        tick();
    endtask

    task automatic test_scalar_lw();
        for (int l = 0; l < 16; l++) line[l] = 32'hDEADBEEF;
        line[3] = 32'h11223344;
        ma_strand = 2; ma_instruction = mem_instr(1, 4'd4); ma_has_writeback = 1;
        ma_writeback_reg = 5; ma_was_load = 1; dcache_hit = 1; ma_cache_lane_select = 3;
        data_from_dcache = line; ma_mask = 16'h0001;
        #1;
        tests_run++; if (wb_rollback_request !== 1'b0) begin tests_failed++; $display("FAIL lw_no_rollback got %0b exp 0", wb_rollback_request); end
        tick(); clear_inputs();
        for (int l = 0; l < 16; l++) expv[l] = 32'h44332211;
        tests_run++; if (wb_has_writeback !== 1'b1) begin tests_failed++; $display("FAIL lw_has_wb got %0b exp 1", wb_has_writeback); end
        tests_run++; if (wb_writeback_value !== expv) begin tests_failed++; $display("FAIL lw_value got %0h exp %0h", wb_writeback_value, expv); end
        tests_run++; if (wb_writeback_mask !== 16'hFFFF) begin tests_failed++; $display("FAIL lw_mask got %h exp ffff", wb_writeback_mask); end
        tests_run++; if (wb_writeback_strand !== 2'd2 || wb_writeback_reg !== 7'd5) begin tests_failed++; $display("FAIL lw_strand_reg got %0d/%0d exp 2/5", wb_writeback_strand, wb_writeback_reg); end
    endtask

    task automatic test_miss_squash();
        ma_strand = 1; ma_instruction = mem_instr(1, 4'd4); ma_has_writeback = 1;
        ma_was_load = 1; dcache_hit = 0; ma_pc = 32'h104;
        #1;
        tests_run++; if (wb_rollback_request !== 1'b1 || wb_rollback_pc !== 32'h100) begin tests_failed++; $display("FAIL miss_rollback got %0b/%h exp 1/00000100", wb_rollback_request, wb_rollback_pc); end
        tests_run++; if (wb_rollback_strand !== 2'd1 || wb_retry !== 1'b0) begin tests_failed++; $display("FAIL miss_rb_strand got %0d/%0b exp 1/0", wb_rollback_strand, wb_retry); end
        tick(); clear_inputs();
        tests_run++; if (strand_waiting !== 4'b0010 || wb_has_writeback !== 1'b0) begin tests_failed++; $display("FAIL miss_wait got %b/%0b exp 0010/0", strand_waiting, wb_has_writeback); end
        ma_strand = 1; ma_instruction = 32'h0000_1234; ma_has_writeback = 1; ma_was_load = 1;
        ma_result = {16{32'hCAFE0001}}; ma_mask = 16'hFFFF; ma_pc = 32'h108;
        #1;
        tests_run++; if (wb_rollback_request !== 1'b0) begin tests_failed++; $display("FAIL squash_rollback got %0b exp 0", wb_rollback_request); end
        tick(); clear_inputs();
        tests_run++; if (wb_has_writeback !== 1'b0 || strand_waiting !== 4'b0010) begin tests_failed++; $display("FAIL squash_wb got %0b/%b exp 0/0010", wb_has_writeback, strand_waiting); end
        resume_strand = 4'b0010;
        tick(); clear_inputs();
        tests_run++; if (strand_waiting !== 4'b0000) begin tests_failed++; $display("FAIL resume got %b exp 0000", strand_waiting); end
        ma_strand = 1; ma_instruction = 32'h0000_1234; ma_has_writeback = 1;
        ma_result = {16{32'hA5A5_0F0F}}; ma_mask = 16'h00FF;
        tick(); clear_inputs();
        tests_run++; if (wb_has_writeback !== 1'b1 || wb_writeback_value !== {16{32'hA5A5_0F0F}} || wb_writeback_mask !== 16'h00FF) begin tests_failed++; $display("FAIL alu_pass got %0b/%h exp 1/00ff", wb_has_writeback, wb_writeback_mask); end
    endtask

    task automatic test_miss_resume_same();
        ma_strand = 3; ma_instruction = mem_instr(1, 4'd4); ma_was_load = 1; ma_pc = 32'h300;
        resume_strand = 4'b1000;
        tick(); clear_inputs();
        tests_run++; if (strand_waiting !== 4'b1000) begin tests_failed++; $display("FAIL miss_resume_same got %b exp 1000", strand_waiting); end
        resume_strand = 4'b1001;
        tick(); clear_inputs();
        tests_run++; if (strand_waiting !== 4'b0000) begin tests_failed++; $display("FAIL resume_active_ignored got %b exp 0000", strand_waiting); end
        ma_strand = 0; ma_instruction = mem_instr(0, 4'd4); stbuf_rollback = 1; ma_pc = 32'h44;
        #1;
        tests_run++; if (wb_rollback_request !== 1'b1 || wb_rollback_pc !== 32'h40) begin tests_failed++; $display("FAIL stbuf_rollback got %0b/%h exp 1/00000040", wb_rollback_request, wb_rollback_pc); end
        tick(); clear_inputs();
        tests_run++; if (strand_waiting !== 4'b0001) begin tests_failed++; $display("FAIL stbuf_wait got %b exp 0001", strand_waiting); end
        resume_strand = 4'b0001;
        tick(); clear_inputs();
    endtask

    task automatic test_align();
        logic [3:0]  ops  [5] = '{4'd1, 4'd0, 4'd3, 4'd2, 4'd4};
        logic [31:0] addr [5] = '{32'h1001, 32'h1001, 32'h1002, 32'h1000, 32'h1000};
        logic [31:0] word [5] = '{32'h00800000, 32'h00800000, 32'h12348001, 32'h80011234, 32'hA1B2C3D4};
        logic [31:0] exp_w [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001, 32'hD4C3B2A1};
        for (int k = 0; k < 5; k++) begin
            line = '0; line[0] = word[k];
            ma_instruction = mem_instr(1, ops[k]); ma_has_writeback = 1; ma_writeback_reg = 3;
            ma_was_load = 1; dcache_hit = 1; ma_result = {16{addr[k]}}; data_from_dcache = line;
            tick(); clear_inputs();
            tests_run++; if (wb_writeback_value !== {16{exp_w[k]}}) begin tests_failed++; $display("FAIL align_%0d got %h exp %h", k, wb_writeback_value[31:0], exp_w[k]); end
        end
        line = '0; line[0] = 32'h00200000;
        ma_instruction = mem_instr(1, 4'd4); ma_has_writeback = 1; ma_writeback_reg = 31;
        ma_was_load = 1; dcache_hit = 1; data_from_dcache = line; ma_pc = 32'h500;
        #1;
        tests_run++; if (wb_rollback_request !== 1'b1 || wb_rollback_pc !== 32'h2000) begin tests_failed++; $display("FAIL r31_rollback got %0b/%h exp 1/00002000", wb_rollback_request, wb_rollback_pc); end
        tick(); clear_inputs();
        tests_run++; if (wb_has_writeback !== 1'b0 || strand_waiting !== 4'b0000) begin tests_failed++; $display("FAIL r31_wb got %0b/%b exp 0/0000", wb_has_writeback, strand_waiting); end
    endtask

    task automatic test_vector_loads();
        line = '0; line[2] = 32'hAABBCCDD;
        ma_instruction = mem_instr(1, 4'd13); ma_has_writeback = 1; ma_writeback_is_vector = 1;
        ma_was_load = 1; dcache_hit = 1; ma_reg_lane_select = 5; ma_cache_lane_select = 2;
        ma_mask = 16'hFFFF; data_from_dcache = line;
        tick();
        tests_run++; if (wb_writeback_mask !== 16'h0020 || wb_writeback_value[5*32 +: 32] !== 32'hDDCCBBAA) begin tests_failed++; $display("FAIL gather got %h/%h exp 0020/ddccbbaa", wb_writeback_mask, wb_writeback_value[5*32 +: 32]); end
        ma_mask = 16'hFFDF;
        tick(); clear_inputs();
        tests_run++; if (wb_writeback_mask !== 16'h0000) begin tests_failed++; $display("FAIL gather_masked got %h exp 0000", wb_writeback_mask); end
        for (int l = 0; l < 16; l++) begin line[l] = {8'(l), 24'h112233}; expv[l] = {24'h332211, 8'(l)}; end
        ma_instruction = mem_instr(1, 4'd7); ma_has_writeback = 1; ma_was_load = 1; dcache_hit = 1;
        ma_mask = 16'h00F0; data_from_dcache = line;
        tick(); clear_inputs();
        tests_run++; if (wb_writeback_value !== expv || wb_writeback_mask !== 16'h00F0) begin tests_failed++; $display("FAIL block got %h/%h exp %h/00f0", wb_writeback_value, wb_writeback_mask, expv); end
        ma_instruction = mem_instr(0, 4'd5); ma_has_writeback = 1; ma_mask = 16'h0000;
        data_from_dcache = line; ma_result = {16{32'h1}};
        tick(); clear_inputs();
        tests_run++; if (wb_writeback_value !== line || wb_writeback_mask !== 16'hFFFF) begin tests_failed++; $display("FAIL sync_store got %h exp ffff", wb_writeback_mask); end
        ma_instruction = mem_instr(1, 4'd4); ma_has_writeback = 1; ma_was_load = 1;
        dcache_load_collision = 1; ma_pc = 32'h208;
        #1;
        tests_run++; if (wb_retry !== 1'b1 || wb_rollback_request !== 1'b1 || wb_rollback_pc !== 32'h204) begin tests_failed++; $display("FAIL collision got %0b/%0b/%h exp 1/1/00000204", wb_retry, wb_rollback_request, wb_rollback_pc); end
        tick(); clear_inputs();
        tests_run++; if (strand_waiting !== 4'b0000 || wb_has_writeback !== 1'b0) begin tests_failed++; $display("FAIL collision_fsm got %b/%0b exp 0000/0", strand_waiting, wb_has_writeback); end
    endtask

    task automatic test_reset_mid_wait();
        ma_strand = 2; ma_instruction = mem_instr(1, 4'd4); ma_was_load = 1; ma_pc = 32'h600;
        tick(); clear_inputs();
        ma_strand = 0; ma_instruction = 32'h0000_0042; ma_has_writeback = 1; ma_result = {16{32'h77}};
        tick(); clear_inputs();
        tests_run++; if (wb_has_writeback !== 1'b1 || strand_waiting !== 4'b0100) begin tests_failed++; $display("FAIL pre_reset got %0b/%b exp 1/0100", wb_has_writeback, strand_waiting); end
        reset_n = 0;
        #1;
        tests_run++; if (wb_has_writeback !== 1'b0 || strand_waiting !== 4'b0000 || wb_writeback_value !== 512'd0) begin tests_failed++; $display("FAIL mid_reset got %0b/%b exp 0/0000", wb_has_writeback, strand_waiting); end
        #2; reset_n = 1;
        tick();
        tests_run++; if (wb_has_writeback !== 1'b0 || strand_waiting !== 4'b0000) begin tests_failed++; $display("FAIL post_reset got %0b/%b exp 0/0000", wb_has_writeback, strand_waiting); end
    endtask

    task automatic test_perf();
        logic [63:0] exp0, exp1;
`ifdef WB_PERF_COUNTERS_EN
        exp0 = 64'd3; exp1 = 64'd1;
`else
        exp0 = 64'd0; exp1 = 64'd0;
`endif
        reset_n = 0; #3; reset_n = 1;
        tick();
        for (int k = 0; k < 3; k++) begin
            ma_strand = 0; ma_instruction = 32'h0000_1000 + 32'(k); ma_has_writeback = 1;
            tick(); clear_inputs();
        end
        ma_strand = 0; ma_instruction = 32'h0;
        tick(); clear_inputs();
        ma_strand = 0; ma_instruction = mem_instr(1, 4'd4); ma_was_load = 1; dcache_load_collision = 1;
        tick(); clear_inputs();
        ma_strand = 1; ma_instruction = 32'h0000_2000;
        tick(); clear_inputs();
        perf_strand_sel = 0;
        #1;
        tests_run++; if (perf_retire_count !== exp0) begin tests_failed++; $display("FAIL perf_strand0 got %0d exp %0d", perf_retire_count, exp0); end
        perf_strand_sel = 1;
        #1;
        tests_run++; if (perf_retire_count !== exp1) begin tests_failed++; $display("FAIL perf_strand1 got %0d exp %0d", perf_retire_count, exp1); end
        perf_strand_sel = 0;
        reset_n = 0;
        #1;
        tests_run++; if (perf_retire_count !== 64'd0) begin tests_failed++; $display("FAIL perf_reset got %0d exp 0", perf_retire_count); end
        #1; reset_n = 1;
        tick();
    endtask

    initial begin
        test_reset();
        test_scalar_lw();
        test_miss_squash();
        test_miss_resume_same();
        test_align();
        test_vector_loads();
        test_reset_mid_wait();
        test_perf();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end
endmodule
